// File: rtl/cv32e40p_alu_reconfig_ft.sv
// ALU reconfiguration controller for the fault-tolerant cv32e40p EX stage.
// Tracks dead ALUs per operation class and selects the healthy subset and voting mode.
module cv32e40p_alu_reconfig_ft #(
   parameter int NUM_ALU      = 3,
   parameter int NUM_CLASS    = 14,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_ALU-1:0]           remove_valid_i,
   input  logic [NUM_ALU-1:0][3:0]      remove_class_i,
   output logic [NUM_ALU-1:0]           remove_ready_o,
   output logic [NUM_ALU-1:0]           counter_clr_o,
   input  logic                         op_valid_i,
   input  logic [3:0]                   op_class_i,
   output logic [2:0]                   alu_sel_o,
   output logic [1:0]                   vote_mode_o,
   output logic                         stall_o,
   output logic                         fatal_o,
   output logic                         bad_class_o,
   output logic [NUM_ALU*NUM_CLASS-1:0] dead_map_o,
   output logic [5:0]                   removed_cnt_o,
   output logic [1:0]                   state_o
);

   // Handshake: a requester raises remove_valid_i[a] with a stable class and holds both
   // until remove_ready_o[a] pulses for one cycle (UPDATE); only that pulse consumes it.

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] UPDATE = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;
   localparam logic [5:0] MAX_REMOVED = 6'(NUM_ALU * NUM_CLASS);

   logic [1:0]           state_q, state_d;
   logic [1:0]           rr_ptr_q;
   logic [1:0]           win_idx_q;
   logic [3:0]           win_class_q;
   logic [3:0]           drain_cnt_q;
   logic [NUM_CLASS-1:0] dead_q [NUM_ALU];
   logic [5:0]           removed_cnt_q;

   logic [1:0]           cand0, cand1, cand2;
   logic                 win_found;
   logic [1:0]           win_idx_d;
   logic                 win_class_ok;
   logic                 win_already_dead;
   logic                 win_new_bit;
   logic                 op_class_ok;
   logic [2:0]           healthy;
   logic [NUM_CLASS-1:0] col_dead;

   function automatic logic [1:0] rr_next(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   assign cand0 = rr_ptr_q;
   assign cand1 = rr_next(cand0);
   assign cand2 = rr_next(cand1);

   always_comb begin
      win_found = 1'b1;
      win_idx_d = cand0;
      if (remove_valid_i[cand0])      win_idx_d = cand0;
      else if (remove_valid_i[cand1]) win_idx_d = cand1;
      else if (remove_valid_i[cand2]) win_idx_d = cand2;
      else                            win_found = 1'b0;
   end

   assign win_class_ok     = (win_class_q < 4'(NUM_CLASS));
   assign win_already_dead = win_class_ok && dead_q[win_idx_q][win_class_q];
   assign win_new_bit      = win_class_ok && !win_already_dead;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (win_found) state_d = UPDATE;
         UPDATE:  state_d = win_new_bit ? DRAIN : IDLE;
         DRAIN:   if (drain_cnt_q == 4'd0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         rr_ptr_q      <= 2'd0;
         win_idx_q     <= 2'd0;
         win_class_q   <= 4'd0;
         drain_cnt_q   <= 4'd0;
         removed_cnt_q <= 6'd0;
         for (int a = 0; a < NUM_ALU; a++) dead_q[a] <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  win_idx_q   <= win_idx_d;
                  win_class_q <= remove_class_i[win_idx_d];
                  rr_ptr_q    <= rr_next(win_idx_d);
               end
            end
            UPDATE: begin
               if (win_new_bit) begin
                  dead_q[win_idx_q][win_class_q] <= 1'b1;
                  drain_cnt_q <= 4'(DRAIN_CYCLES - 1);
                  if (removed_cnt_q != MAX_REMOVED) removed_cnt_q <= removed_cnt_q + 6'd1;
               end
            end
            DRAIN: begin
               if (drain_cnt_q != 4'd0) drain_cnt_q <= drain_cnt_q - 4'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      remove_ready_o = '0;
      bad_class_o    = 1'b0;
      if (state_q == UPDATE) begin
         remove_ready_o[win_idx_q] = 1'b1;
         bad_class_o               = !win_class_ok;
      end
   end

   assign counter_clr_o = remove_ready_o;
   // Holding off issue while a request is merely pending keeps ops away from a stale map.
   assign stall_o       = (state_q != IDLE) || (|remove_valid_i);

   assign op_class_ok = (op_class_i < 4'(NUM_CLASS));

   always_comb begin
      healthy     = '0;
      alu_sel_o   = 3'b000;
      vote_mode_o = 2'b00;
      if (op_valid_i && op_class_ok) begin
         for (int a = 0; a < NUM_ALU; a++) healthy[a] = !dead_q[a][op_class_i];
         alu_sel_o = healthy;
         case (healthy)
            3'b111:                 vote_mode_o = 2'b00;
            3'b011, 3'b101, 3'b110: vote_mode_o = 2'b01;
            3'b001, 3'b010, 3'b100: vote_mode_o = 2'b10;
            default:                vote_mode_o = 2'b11;
         endcase
      end
   end

   // Dead bits only clear on reset, so an all-dead column is already sticky.
   assign col_dead = dead_q[0] & dead_q[1] & dead_q[2];
   assign fatal_o  = |col_dead;

   for (genvar a = 0; a < NUM_ALU; a++) begin : g_map
      assign dead_map_o[a*NUM_CLASS +: NUM_CLASS] = dead_q[a];
   end

   assign removed_cnt_o = removed_cnt_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_cv32e40p_alu_reconfig_ft.sv
// Bench for cv32e40p_alu_reconfig_ft: acks are checked against an expected queue,
// map/selection/stall are checked inline per scenario.
module tb_cv32e40p_alu_reconfig_ft;

   localparam int NA = 3;
   localparam int NC = 14;

   logic            clk;
   logic            rst;
   logic [NA-1:0]   remove_valid_i;
   logic [NA-1:0][3:0] remove_class_i;
   logic [NA-1:0]   remove_ready_o;
   logic [NA-1:0]   counter_clr_o;
   logic            op_valid_i;
   logic [3:0]      op_class_i;
   logic [2:0]      alu_sel_o;
   logic [1:0]      vote_mode_o;
   logic            stall_o;
   logic            fatal_o;
   logic            bad_class_o;
   logic [NA*NC-1:0] dead_map_o;
   logic [5:0]      removed_cnt_o;
   logic [1:0]      state_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [6:0] exp_q[$];
   int ack_cyc_q[$];
   logic [2:0] acked;

   cv32e40p_alu_reconfig_ft #(.NUM_ALU(3), .NUM_CLASS(14), .DRAIN_CYCLES(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .remove_valid_i (remove_valid_i),
      .remove_class_i (remove_class_i),
      .remove_ready_o (remove_ready_o),
      .counter_clr_o  (counter_clr_o),
      .op_valid_i     (op_valid_i),
      .op_class_i     (op_class_i),
      .alu_sel_o      (alu_sel_o),
      .vote_mode_o    (vote_mode_o),
      .stall_o        (stall_o),
      .fatal_o        (fatal_o),
      .bad_class_o    (bad_class_o),
      .dead_map_o     (dead_map_o),
      .removed_cnt_o  (removed_cnt_o),
      .state_o        (state_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Mid-cycle sample; any ack pulse is popped from the expected queue.
   task automatic sample();
      logic [6:0] got;
      logic [6:0] exp;
      @(negedge clk);
      if (remove_ready_o != 3'b000 || counter_clr_o != 3'b000 || bad_class_o) begin
         got = {bad_class_o, remove_ready_o, counter_clr_o};
         acked = remove_ready_o;
         ack_cyc_q.push_back(cyc);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ack_unexpected cyc=%0d got=%b required=none", cyc, got);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL ack cyc=%0d got=%b required=%b", cyc, got, exp);
            end
         end
      end
   endtask

   // Just past the edge: requesters drop the valid that was acked last cycle.
   task automatic cyc_end();
      @(posedge clk);
      #1;
      remove_valid_i = remove_valid_i & ~acked;
      acked = 3'b000;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      remove_valid_i = 3'b000;
      acked = 3'b000;
      sample(); cyc_end();
      sample(); cyc_end();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      op_valid_i = 1'b1;
      op_class_i = 4'd3;
      sample();
      checks++;
      if ({alu_sel_o, vote_mode_o, stall_o, fatal_o} !== {3'b111, 2'b00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_sel got=%b/%b/%b/%b required=111/00/0/0", alu_sel_o, vote_mode_o, stall_o, fatal_o);
      end
      checks++;
      if (removed_cnt_o !== 6'd0 || dead_map_o !== '0 || state_o !== 2'd0) begin
         errors++;
         $display("FAIL reset_state got=%0d/%h/%0d required=0/0/0", removed_cnt_o, dead_map_o, state_o);
      end
      op_valid_i = 1'b0;
      #1;
      checks++;
      if ({alu_sel_o, vote_mode_o} !== 5'b000_00) begin
         errors++;
         $display("FAIL reset_noop got=%b/%b required=000/00", alu_sel_o, vote_mode_o);
      end
      cyc_end();
      rst = 1'b0;
      op_valid_i = 1'b1;
      sample();
      checks++;
      if ({alu_sel_o, vote_mode_o, stall_o} !== {3'b111, 2'b00, 1'b0}) begin
         errors++;
         $display("FAIL reset_release got=%b/%b/%b required=111/00/0", alu_sel_o, vote_mode_o, stall_o);
      end
      cyc_end();
   endtask

   task automatic test_single();
      logic [NA*NC-1:0] exp_map;
      do_reset();
      op_valid_i = 1'b1;
      op_class_i = 4'd0;
      remove_class_i[1] = 4'd0;
      remove_valid_i = 3'b010;
      exp_q.push_back({1'b0, 3'b010, 3'b010});
      sample();
      checks++;
      if (stall_o !== 1'b1 || remove_ready_o !== 3'b000) begin
         errors++;
         $display("FAIL single_n got=%b/%b required=1/000", stall_o, remove_ready_o);
      end
      cyc_end();
      sample();
      checks++;
      if (remove_ready_o !== 3'b010 || stall_o !== 1'b1 || alu_sel_o !== 3'b111) begin
         errors++;
         $display("FAIL single_n1 got=%b/%b/%b required=010/1/111", remove_ready_o, stall_o, alu_sel_o);
      end
      cyc_end();
      sample();
      exp_map = '0;
      exp_map[1*NC + 0] = 1'b1;
      checks++;
      if ({alu_sel_o, vote_mode_o, stall_o} !== {3'b101, 2'b01, 1'b1}) begin
         errors++;
         $display("FAIL single_sel got=%b/%b/%b required=101/01/1", alu_sel_o, vote_mode_o, stall_o);
      end
      checks++;
      if (dead_map_o !== exp_map || removed_cnt_o !== 6'd1) begin
         errors++;
         $display("FAIL single_map got=%h/%0d required=%h/1", dead_map_o, removed_cnt_o, exp_map);
      end
      cyc_end();
      sample();
      checks++;
      if (stall_o !== 1'b1) begin
         errors++;
         $display("FAIL single_n3 got=%b required=1", stall_o);
      end
      cyc_end();
      sample();
      checks++;
      if (stall_o !== 1'b0) begin
         errors++;
         $display("FAIL single_n4 got=%b required=0", stall_o);
      end
      cyc_end();
   endtask

   task automatic test_simultaneous();
      logic [NA*NC-1:0] exp_map;
      bit mid_checked;
      do_reset();
      op_valid_i = 1'b1;
      op_class_i = 4'd2;
      remove_class_i = {4'd2, 4'd2, 4'd2};
      remove_valid_i = 3'b111;
      exp_q.push_back({1'b0, 3'b001, 3'b001});
      exp_q.push_back({1'b0, 3'b010, 3'b010});
      exp_q.push_back({1'b0, 3'b100, 3'b100});
      ack_cyc_q.delete();
      mid_checked = 1'b0;
      for (int i = 0; i < 16; i++) begin
         sample();
         if (!mid_checked && removed_cnt_o == 6'd2) begin
            mid_checked = 1'b1;
            checks++;
            if ({alu_sel_o, vote_mode_o} !== {3'b100, 2'b10}) begin
               errors++;
               $display("FAIL simul_simplex got=%b/%b required=100/10", alu_sel_o, vote_mode_o);
            end
         end
         cyc_end();
      end
      checks++;
      if (ack_cyc_q.size() != 3) begin
         errors++;
         $display("FAIL simul_acks got=%0d required=3", ack_cyc_q.size());
      end else begin
         if (ack_cyc_q[1] - ack_cyc_q[0] != 4 || ack_cyc_q[2] - ack_cyc_q[1] != 4) begin
            errors++;
            $display("FAIL simul_spacing got=%0d,%0d required=4,4",
                     ack_cyc_q[1] - ack_cyc_q[0], ack_cyc_q[2] - ack_cyc_q[1]);
         end
      end
      sample();
      exp_map = '0;
      exp_map[0*NC + 2] = 1'b1;
      exp_map[1*NC + 2] = 1'b1;
      exp_map[2*NC + 2] = 1'b1;
      checks++;
      if ({alu_sel_o, vote_mode_o, fatal_o, stall_o} !== {3'b000, 2'b11, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL simul_final got=%b/%b/%b/%b required=000/11/1/0", alu_sel_o, vote_mode_o, fatal_o, stall_o);
      end
      checks++;
      if (dead_map_o !== exp_map || removed_cnt_o !== 6'd3) begin
         errors++;
         $display("FAIL simul_map got=%h/%0d required=%h/3", dead_map_o, removed_cnt_o, exp_map);
      end
      cyc_end();
   endtask

   task automatic test_dup();
      logic [NA*NC-1:0] exp_map;
      do_reset();
      op_valid_i = 1'b1;
      op_class_i = 4'd5;
      remove_class_i[2] = 4'd5;
      remove_valid_i = 3'b100;
      exp_q.push_back({1'b0, 3'b100, 3'b100});
      repeat (6) begin sample(); cyc_end(); end
      ack_cyc_q.delete();
      remove_valid_i = 3'b100;
      exp_q.push_back({1'b0, 3'b100, 3'b100});
      sample(); cyc_end();
      sample(); cyc_end();
      remove_valid_i = 3'b100;
      exp_q.push_back({1'b0, 3'b100, 3'b100});
      sample(); cyc_end();
      sample(); cyc_end();
      sample();
      exp_map = '0;
      exp_map[2*NC + 5] = 1'b1;
      checks++;
      if (stall_o !== 1'b0 || removed_cnt_o !== 6'd1 || dead_map_o !== exp_map) begin
         errors++;
         $display("FAIL dup_map got=%b/%0d/%h required=0/1/%h", stall_o, removed_cnt_o, dead_map_o, exp_map);
      end
      checks++;
      if ({alu_sel_o, vote_mode_o} !== {3'b011, 2'b01}) begin
         errors++;
         $display("FAIL dup_sel got=%b/%b required=011/01", alu_sel_o, vote_mode_o);
      end
      checks++;
      if (ack_cyc_q.size() != 2) begin
         errors++;
         $display("FAIL dup_acks got=%0d required=2", ack_cyc_q.size());
      end else if (ack_cyc_q[1] - ack_cyc_q[0] != 2) begin
         errors++;
         $display("FAIL dup_spacing got=%0d required=2", ack_cyc_q[1] - ack_cyc_q[0]);
      end
      cyc_end();
   endtask

   task automatic test_bad_class();
      do_reset();
      op_valid_i = 1'b1;
      op_class_i = 4'd14;
      remove_class_i[0] = 4'd14;
      remove_valid_i = 3'b001;
      exp_q.push_back({1'b1, 3'b001, 3'b001});
      sample(); cyc_end();
      sample();
      checks++;
      if (bad_class_o !== 1'b1) begin
         errors++;
         $display("FAIL bad_pulse got=%b required=1", bad_class_o);
      end
      cyc_end();
      sample();
      checks++;
      if (dead_map_o !== '0 || removed_cnt_o !== 6'd0 || stall_o !== 1'b0 || bad_class_o !== 1'b0) begin
         errors++;
         $display("FAIL bad_after got=%h/%0d/%b/%b required=0/0/0/0", dead_map_o, removed_cnt_o, stall_o, bad_class_o);
      end
      checks++;
      if ({alu_sel_o, vote_mode_o} !== 5'b000_00) begin
         errors++;
         $display("FAIL bad_opclass got=%b/%b required=000/00", alu_sel_o, vote_mode_o);
      end
      cyc_end();
   endtask

   task automatic test_reset_drain();
      logic [NA*NC-1:0] exp_map;
      do_reset();
      op_valid_i = 1'b1;
      op_class_i = 4'd4;
      remove_class_i[1] = 4'd4;
      remove_valid_i = 3'b010;
      exp_q.push_back({1'b0, 3'b010, 3'b010});
      sample(); cyc_end();
      sample(); cyc_end();
      sample();
      exp_map = '0;
      exp_map[1*NC + 4] = 1'b1;
      checks++;
      if (dead_map_o !== exp_map || stall_o !== 1'b1) begin
         errors++;
         $display("FAIL rstdrain_pre got=%h/%b required=%h/1", dead_map_o, stall_o, exp_map);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (dead_map_o !== '0 || stall_o !== 1'b0 || removed_cnt_o !== 6'd0 || alu_sel_o !== 3'b111) begin
         errors++;
         $display("FAIL rstdrain_clear got=%h/%b/%0d/%b required=0/0/0/111", dead_map_o, stall_o, removed_cnt_o, alu_sel_o);
      end
      cyc_end();
      remove_valid_i = 3'b010;
      exp_q.push_back({1'b0, 3'b010, 3'b010});
      sample(); cyc_end();
      rst = 1'b0;
      repeat (6) begin sample(); cyc_end(); end
      sample();
      checks++;
      if (dead_map_o !== exp_map || removed_cnt_o !== 6'd1 || remove_valid_i !== 3'b000) begin
         errors++;
         $display("FAIL rstdrain_reack got=%h/%0d/%b required=%h/1/000", dead_map_o, removed_cnt_o, remove_valid_i, exp_map);
      end
      cyc_end();
   endtask

   initial begin
      rst = 1'b1;
      remove_valid_i = 3'b000;
      remove_class_i = '0;
      op_valid_i = 1'b0;
      op_class_i = 4'd0;
      acked = 3'b000;
      test_reset();
      test_single();
      test_simultaneous();
      test_dup();
      test_bad_class();
      test_reset_drain();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL ack_missing got=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
